// File: rtl/alu_serial_ctrl_if.sv
// Bundle between the op-issue side, the bit-serial controller and the shared 1-bit ALU slice.
// The slave modport is the controller; the master modport is the issuer plus slice.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic [7:0]       decoder_x;
    logic             alu_a;
    logic             alu_b;
    logic             alu_cin;
    logic             alu_x;
    logic             alu_cout;

    modport slave (
        input  start, mode, op_a, op_b, cin, alu_x, alu_cout,
        output busy, done, err, result, c_flag, decoder_x, alu_a, alu_b, alu_cin
    );

    modport master (
        output start, mode, op_a, op_b, cin, alu_x, alu_cout,
        input  busy, done, err, result, c_flag, decoder_x, alu_a, alu_b, alu_cin
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds a shared 1-bit ALU slice LSB-first for WIDTH cycles,
// carries the slice C_out between bits and collects X into the result register.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               CLK,
    input logic               RST,
    alu_serial_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [2:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_flag_q, c_flag_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            mode_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            c_flag_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            c_flag_q <= c_flag_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        c_flag_d = c_flag_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d = bus.op_a;
                    b_sh_d = bus.op_b;
                    mode_d = bus.mode;
                    cnt_d  = '0;
                    if (bus.mode <= 3'd4) begin
                        carry_d = (bus.mode == 3'd0) ? bus.cin : 1'b0;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        // Illegal op skips RUN entirely and reports through DONE
                        carry_d  = 1'b0;
                        err_d    = 1'b1;
                        result_d = '0;
                        c_flag_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                result_d = {bus.alu_x, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                if (mode_q == 3'd0) begin
                    carry_d  = bus.alu_cout;
                    c_flag_d = bus.alu_cout;
                end else begin
                    c_flag_d = 1'b0;
                end
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slice drive depends only on registered state, never on the request inputs
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.result    = result_q;
    assign bus.c_flag    = c_flag_q;
    assign bus.decoder_x = (state_q == RUN) ? (8'h01 << mode_q) : 8'h00;
    assign bus.alu_a     = a_sh_q[0];
    assign bus.alu_b     = b_sh_q[0];
    assign bus.alu_cin   = carry_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a behavioural 1-bit ALU slice and a word-level reference model.
module tb_alu_serial_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU slice selected by the one-hot decoder
    logic slice_x, slice_co;
    always_comb begin
        slice_x  = 1'b0;
        slice_co = 1'b0;
        case (bus.decoder_x)
            8'h01: begin
                slice_x  = bus.alu_a ^ bus.alu_b ^ bus.alu_cin;
                slice_co = (bus.alu_a & bus.alu_b) | (bus.alu_cin & (bus.alu_a ^ bus.alu_b));
            end
            8'h02: slice_x = bus.alu_a & bus.alu_b;
            8'h04: slice_x = bus.alu_a | bus.alu_b;
            8'h08: slice_x = bus.alu_a ^ bus.alu_b;
            8'h10: slice_x = ~(bus.alu_a ^ bus.alu_b);
            default: ;
        endcase
    end
    assign bus.alu_x    = slice_x;
    assign bus.alu_cout = slice_co;

    // Word-level reference: returns {err, c_flag, result}
    function automatic logic [WIDTH+1:0] ref_op(input logic [2:0] m, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic c);
        logic [WIDTH:0] sum;
        case (m)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
                return {1'b0, sum};
            end
            3'd1: return {2'b00, a & b};
            3'd2: return {2'b00, a | b};
            3'd3: return {2'b00, a ^ b};
            3'd4: return {2'b00, ~(a ^ b)};
            default: return {2'b10, {WIDTH{1'b0}}};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'd0);
        chk({tag, ".err"}, 32'(bus.err), 32'd0);
        chk({tag, ".result"}, 32'(bus.result), 32'd0);
        chk({tag, ".c_flag"}, 32'(bus.c_flag), 32'd0);
        chk({tag, ".decoder_x"}, 32'(bus.decoder_x), 32'd0);
        chk({tag, ".alu"}, {29'd0, bus.alu_a, bus.alu_b, bus.alu_cin}, 32'd0);
    endtask

    // Issue one op from IDLE and check timing and outcome; inj_k >= 0 re-pulses start at that RUN bit
    task automatic run_op(input string tag, input logic [2:0] m, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic c, input int inj_k);
        logic [WIDTH+1:0] exp;
        int n;
        exp = ref_op(m, a, b, c);
        @(negedge clk);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.mode = m; bus.op_a = a; bus.op_b = b; bus.cin = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a = WIDTH'($urandom); bus.op_b = WIDTH'($urandom); bus.cin = 1'($urandom);
        bus.mode = 3'($urandom);
        if (m <= 3'd4) begin
            chk({tag, ".dec"}, 32'(bus.decoder_x), 32'(8'h01 << m));
            chk({tag, ".cin0"}, 32'(bus.alu_cin), 32'((m == 3'd0) & c));
            chk({tag, ".a0b0"}, {30'd0, bus.alu_a, bus.alu_b}, {30'd0, a[0], b[0]});
        end
        for (n = 1; n < 30; n++) begin
            if (bus.done) break;
            chk({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
            bus.start = (inj_k >= 0 && n == inj_k + 1);
            if (bus.start) begin
                bus.mode = 3'd2; bus.op_a = ~a; bus.op_b = ~b;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, ".latency"}, 32'(n), (m <= 3'd4) ? 32'(WIDTH + 1) : 32'd1);
        chk({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
        chk({tag, ".result"}, 32'(bus.result), 32'(exp[WIDTH-1:0]));
        chk({tag, ".c_flag"}, 32'(bus.c_flag), 32'(exp[WIDTH]));
        chk({tag, ".err"}, 32'(bus.err), 32'(exp[WIDTH+1]));
        @(negedge clk);
        chk({tag, ".done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        chk({tag, ".held"}, 32'({bus.err, bus.c_flag, bus.result}), 32'(exp));
    endtask

    initial begin
        int n;
        int d1;
        bus.start = 1'b0; bus.mode = '0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // T1..T4 directed cases
        run_op("t1_add", 3'd0, 8'h5A, 8'h3C, 1'b0, -1);
        run_op("t2_add_ff", 3'd0, 8'hFF, 8'h00, 1'b1, -1);
        run_op("t2_add_7f", 3'd0, 8'h7F, 8'h01, 1'b0, -1);
        run_op("t3_and", 3'd1, 8'hF0, 8'h3C, 1'b1, -1);
        run_op("t3_or", 3'd2, 8'hF0, 8'h3C, 1'b1, -1);
        run_op("t3_xor", 3'd3, 8'hF0, 8'h3C, 1'b0, -1);
        run_op("t3_xnor", 3'd4, 8'hF0, 8'h3C, 1'b0, -1);
        run_op("t4_illegal", 3'd5, 8'hAA, 8'h55, 1'b1, -1);
        run_op("t4_add", 3'd0, 8'h01, 8'h01, 1'b0, -1);
        run_op("t4_illegal7", 3'd7, 8'h12, 8'h34, 1'b0, -1);

        // T5 start re-pulsed mid-RUN must be ignored
        run_op("t5_ignore", 3'd0, 8'h21, 8'h43, 1'b1, 3);

        // T6 reset during RUN bit 4 aborts the op
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd0; bus.op_a = 8'hC3; bus.op_b = 8'h5A; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("t6_abort");
        d1 = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) d1++;
        end
        chk("t6_no_done", 32'(d1), 32'd0);
        run_op("t6_fresh", 3'd0, 8'h10, 8'h20, 1'b0, -1);

        // Start held high: one op per WIDTH+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd0; bus.op_a = 8'h12; bus.op_b = 8'h34; bus.cin = 1'b0;
        d1 = -1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                chk("b2b_result", 32'(bus.result), 32'h46);
                if (d1 < 0) d1 = n;
                else break;
            end
        end
        chk("b2b_interval", 32'(n - d1), 32'(WIDTH + 2));
        bus.start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
